lightio_link: RTL and testbench

LIGHTIO_LINK -- requirements
Module: lightio_link

---
 rtl/lightio_link.sv | 271 +++++++++++++++++++++++++++
 tb/tb_lightio_link.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lightio_link.sv
// Optical serial link: TX FIFO feeding a framed serialiser on led, and a mid-bit sampling
// receiver on a synchronised signal input (or the internal TX line in loopback).
module lightio_link #(
  parameter int unsigned FRAME_SIZE = 8,
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned TX_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [FRAME_SIZE-1:0] data_in,
  input  logic                  signal,
  input  logic                  loopback,
  output logic                  led,
  output logic [FRAME_SIZE-1:0] data_out,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  irq_tx,
  output logic                  irq_rx,
  output logic                  err_parity,
  output logic                  err_frame,
  output logic                  overrun
);

  localparam int unsigned PtrW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam int unsigned IdxW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [IdxW-1:0] IdxTop  = IdxW'(FRAME_SIZE - 1);
  localparam logic [PtrW:0]   Full    = (PtrW + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxRecover} rx_state_e;

  // FIFO
  logic [FRAME_SIZE-1:0] mem_q [TX_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]         count_q, count_d;
  logic                  push, pop, fifo_empty;

  // TX
  tx_state_e             tx_state_q, tx_state_d;
  logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [IdxW-1:0]       tx_idx_q, tx_idx_d;
  logic [FRAME_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_line_q, tx_line_d;
  logic                  led_q, led_d;
  logic                  irq_tx_q, irq_tx_d;

  // RX
  logic [1:0]            sync_q, sync_d;
  logic                  rx_in, rx_tick;
  rx_state_e             rx_state_q, rx_state_d;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [IdxW-1:0]       rx_idx_q, rx_idx_d;
  logic [FRAME_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_par_q, rx_par_d;
  logic [FRAME_SIZE-1:0] data_out_q, data_out_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  irq_rx_q, irq_rx_d;
  logic                  err_parity_q, err_parity_d;
  logic                  err_frame_q, err_frame_d;
  logic                  overrun_q, overrun_d;

  assign tx_ready   = (count_q != Full);
  assign push       = tx_valid & tx_ready;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    irq_tx_d   = 1'b0;
    if (tx_state_q == TxIdle) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        tx_shift_d = mem_q[rptr_q];
        tx_state_d = TxStart;
        tx_cnt_d   = '0;
      end
    end else if (tx_cnt_q != CntLast) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        TxStart: begin
          tx_state_d = TxData;
          tx_idx_d   = IdxTop;
        end
        TxData: begin
          if (tx_idx_q == '0) tx_state_d = TxParity;
          else                tx_idx_d   = tx_idx_q - 1'b1;
        end
        TxParity: tx_state_d = TxStop;
        TxStop: begin
          irq_tx_d = 1'b1;
          // Chain straight into the next start bit when more words are queued.
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_d = mem_q[rptr_q];
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  always_comb begin
    case (tx_state_q)
      TxStart:  tx_line_d = 1'b1;
      TxData:   tx_line_d = tx_shift_q[tx_idx_q];
      TxParity: tx_line_d = ^tx_shift_q;
      default:  tx_line_d = 1'b0;
    endcase
    led_d = tx_line_d & ~loopback;
  end

  assign sync_d  = {sync_q[0], signal};
  assign rx_in   = loopback ? tx_line_q : sync_q[1];
  assign rx_tick = (rx_cnt_q == CntLast);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_par_d     = rx_par_q;
    data_out_d   = data_out_q;
    rx_valid_d   = rx_valid_q & ~rx_ack;
    irq_rx_d     = 1'b0;
    err_parity_d = 1'b0;
    err_frame_d  = 1'b0;
    overrun_d    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_in) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d = '0;
          if (rx_in) begin
            rx_state_d = RxData;
            rx_idx_d   = IdxTop;
          end else begin
            rx_state_d = RxIdle;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData, RxParity, RxStop: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end else begin
          rx_cnt_d = '0;
          if (rx_state_q == RxData) begin
            rx_shift_d[rx_idx_q] = rx_in;
            if (rx_idx_q == '0) rx_state_d = RxParity;
            else                rx_idx_d   = rx_idx_q - 1'b1;
          end else if (rx_state_q == RxParity) begin
            rx_par_d   = rx_in;
            rx_state_d = RxStop;
          end else if (rx_in) begin
            err_frame_d = 1'b1;
            rx_state_d  = RxRecover;
          end else if (rx_par_q != ^rx_shift_q) begin
            err_parity_d = 1'b1;
            rx_state_d   = RxIdle;
          end else begin
            // A fresh load wins over a same-cycle acknowledge.
            data_out_d = rx_shift_q;
            rx_valid_d = 1'b1;
            irq_rx_d   = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
            rx_state_d = RxIdle;
          end
        end
      end
      RxRecover: if (!rx_in) rx_state_d = RxIdle;
      default:   rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      tx_state_q   <= TxIdle;
      tx_cnt_q     <= '0;
      tx_idx_q     <= '0;
      tx_shift_q   <= '0;
      tx_line_q    <= 1'b0;
      led_q        <= 1'b0;
      irq_tx_q     <= 1'b0;
      sync_q       <= '0;
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      data_out_q   <= '0;
      rx_valid_q   <= 1'b0;
      irq_rx_q     <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      led_q        <= led_d;
      irq_tx_q     <= irq_tx_d;
      sync_q       <= sync_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
      data_out_q   <= data_out_d;
      rx_valid_q   <= rx_valid_d;
      irq_rx_q     <= irq_rx_d;
      err_parity_q <= err_parity_d;
      err_frame_q  <= err_frame_d;
      overrun_q    <= overrun_d;
    end
  end

  assign led        = led_q;
  assign data_out   = data_out_q;
  assign rx_valid   = rx_valid_q;
  assign irq_tx     = irq_tx_q;
  assign irq_rx     = irq_rx_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lightio_link.sv
// Self-checking bench for lightio_link: loopback frames, FIFO burst with external loop-back,
// directed and random received frames, and mid-frame reset.
module tb_lightio_link;

  localparam int unsigned FS        = 8;
  localparam int unsigned BC        = 16;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FRAME_CYC = (FS + 3) * BC;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          tx_valid = 1'b0;
  logic          loopback = 1'b0;
  logic          rx_ack = 1'b0;
  logic          sig_drv = 1'b0;
  logic          ext_loop = 1'b0;
  logic [FS-1:0] data_in = '0;
  logic          signal;
  logic          tx_ready, led, rx_valid, irq_tx, irq_rx, err_parity, err_frame, overrun;
  logic [FS-1:0] data_out;

  assign signal = ext_loop ? led : sig_drv;

  lightio_link #(.FRAME_SIZE(FS), .BIT_CYCLES(BC), .TX_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .data_in(data_in), .signal(signal), .loopback(loopback), .led(led),
    .data_out(data_out), .rx_valid(rx_valid), .rx_ack(rx_ack), .irq_tx(irq_tx),
    .irq_rx(irq_rx), .err_parity(err_parity), .err_frame(err_frame), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_irq_tx = 0, n_irq_rx = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, n_led_hi = 0, n_long = 0;
  int irq_tx_at = 0;
  bit cap_en = 1'b0;
  logic led_cap[$];
  logic [FS-1:0] rx_words[$];
  logic [4:0] pulses;
  logic [4:0] prev_pulses = '0;

  assign pulses = {irq_tx, irq_rx, err_parity, err_frame, overrun};

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (irq_tx) begin
      n_irq_tx  <= n_irq_tx + 1;
      irq_tx_at <= cyc;
    end
    if (irq_rx) begin
      n_irq_rx <= n_irq_rx + 1;
      rx_words.push_back(data_out);
    end
    if (err_parity) n_perr <= n_perr + 1;
    if (err_frame)  n_ferr <= n_ferr + 1;
    if (overrun)    n_ovr <= n_ovr + 1;
    if (led)        n_led_hi <= n_led_hi + 1;
    if ((pulses & prev_pulses) != '0) n_long <= n_long + 1;
    prev_pulses <= pulses;
    if (cap_en) led_cap.push_back(led);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Line image of one frame, first transmitted bit in the MSB.
  function automatic logic [FS+2:0] frame_bits(input logic [FS-1:0] w, input bit bad_par,
                                               input bit stop);
    return {1'b1, w, (^w) ^ bad_par, stop};
  endfunction

  task automatic send_frame(input logic [FS-1:0] w, input bit bad_par, input bit stop,
                            input int stop_bits);
    logic [FS+2:0] fb;
    fb = frame_bits(w, bad_par, stop);
    for (int b = FS + 2; b >= 1; b--) begin
      sig_drv = fb[b];
      step(BC);
    end
    sig_drv = stop;
    step(BC * stop_bits);
    sig_drv = 1'b0;
    step(2 * BC);
  endtask

  initial begin
    logic [FS-1:0] w;
    logic [FS-1:0] exp_q[$];
    logic [FS-1:0] exp_data;
    logic [FS+2:0] fb;
    bit   exp_valid;
    int   t0, r0, l0, o0, p0, f0, e, mism, mode;
    int   exp_irq, exp_perr, exp_ferr, exp_ovr;

    // Reset state
    step(3);
    check("rst_led", int'(led), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_pulses", int'(pulses), 0);
    reset = 1'b1;
    step(2);

    // Internal loopback: led held low, RX sees the internal line
    loopback = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? FS'(8'hA5) : FS'($urandom);
      t0 = n_irq_tx; r0 = n_irq_rx; l0 = n_led_hi;
      data_in = w; tx_valid = 1'b1;
      step(1);
      e = cyc;
      tx_valid = 1'b0;
      for (int i = 0; i < FRAME_CYC + 40 && (n_irq_tx == t0 || n_irq_rx == r0); i++) step(1);
      step(2);
      check("lb_irq_tx_count", n_irq_tx - t0, 1);
      check("lb_irq_rx_count", n_irq_rx - r0, 1);
      check("lb_irq_tx_latency", irq_tx_at - e, FRAME_CYC + 1);
      check("lb_data_out", int'(data_out), int'(w));
      check("lb_rx_valid", int'(rx_valid), 1);
      check("lb_led_low", n_led_hi - l0, 0);
      rx_ack = 1'b1;
      step(1);
      rx_ack = 1'b0;
      check("lb_ack_clears", int'(rx_valid), 0);
    end

    // Burst into an idle FIFO with led wired back to signal
    loopback = 1'b0;
    ext_loop = 1'b1;
    step(4);
    t0 = n_irq_tx; o0 = n_ovr;
    rx_words.delete();
    led_cap.delete();
    for (int k = 0; k < DEPTH + 2; k++) begin
      w = FS'($urandom);
      data_in = w; tx_valid = 1'b1;
      step(1);
      if (k == 0) cap_en = 1'b1;
      if (k <= DEPTH) exp_q.push_back(w);
      check("burst_tx_ready", int'(tx_ready), (k < DEPTH) ? 1 : 0);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < (DEPTH + 1) * FRAME_CYC + 100 && n_irq_tx < t0 + DEPTH + 1; i++) step(1);
    step(FRAME_CYC + 20);
    cap_en = 1'b0;
    check("burst_irq_tx_count", n_irq_tx - t0, DEPTH + 1);
    check("burst_led_pre", int'(led_cap[1]), 0);
    check("burst_led_first", int'(led_cap[2]), 1);
    for (int f = 0; f <= DEPTH; f++) begin
      fb = frame_bits(exp_q[f], 1'b0, 1'b0);
      mism = 0;
      for (int j = 0; j < FS + 3; j++)
        for (int c = 0; c < BC; c++)
          if (led_cap[2 + f * FRAME_CYC + j * BC + c] !== fb[FS + 2 - j]) mism++;
      check("burst_led_frame", mism, 0);
    end
    mism = 0;
    for (int c = 0; c < 4 * BC; c++)
      if (led_cap[2 + (DEPTH + 1) * FRAME_CYC + c] !== 1'b0) mism++;
    check("burst_led_tail", mism, 0);
    check("burst_rx_count", rx_words.size(), DEPTH + 1);
    for (int f = 0; f <= DEPTH; f++) check("burst_rx_word", int'(rx_words[f]), int'(exp_q[f]));
    check("burst_overruns", n_ovr - o0, DEPTH);
    check("burst_rx_valid", int'(rx_valid), 1);

    // Acknowledge held across a load: the load wins, no overrun
    w = FS'($urandom);
    rx_ack = 1'b1;
    data_in = w; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40 && !irq_rx; i++) step(1);
    check("ackload_irq_rx", int'(irq_rx), 1);
    check("ackload_rx_valid", int'(rx_valid), 1);
    check("ackload_overrun", int'(overrun), 0);
    check("ackload_data", int'(data_out), int'(w));
    rx_ack = 1'b0;
    step(FRAME_CYC);
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;

    // Externally driven frames
    ext_loop = 1'b0;
    sig_drv = 1'b0;
    step(BC);
    exp_data = w;
    exp_valid = 1'b0;
    r0 = n_irq_rx; p0 = n_perr;
    send_frame(FS'(8'h3C), 1'b1, 1'b0, 1);
    check("par_err_pulse", n_perr - p0, 1);
    check("par_no_irq", n_irq_rx - r0, 0);
    check("par_data_kept", int'(data_out), int'(exp_data));
    check("par_valid_kept", int'(rx_valid), int'(exp_valid));

    r0 = n_irq_rx; f0 = n_ferr;
    send_frame(FS'(8'h81), 1'b0, 1'b1, 3);
    check("frm_err_pulse", n_ferr - f0, 1);
    check("frm_no_irq", n_irq_rx - r0, 0);
    check("frm_data_kept", int'(data_out), int'(exp_data));
    send_frame(FS'(8'h81), 1'b0, 1'b0, 1);
    check("recover_irq_rx", n_irq_rx - r0, 1);
    check("recover_data", int'(data_out), 'h81);

    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    o0 = n_ovr;
    send_frame(FS'(8'h11), 1'b0, 1'b0, 1);
    send_frame(FS'(8'h22), 1'b0, 1'b0, 1);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_data", int'(data_out), 'h22);
    exp_data = FS'(8'h22);
    exp_valid = 1'b1;

    // Random frames against the outcome model
    r0 = n_irq_rx; p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    exp_irq = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
    for (int k = 0; k < 10; k++) begin
      w = FS'($urandom);
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
      end
      send_frame(w, mode == 1, mode == 2, 1);
      if (mode == 0) begin
        if (exp_valid) exp_ovr++;
        exp_irq++;
        exp_data = w;
        exp_valid = 1'b1;
      end else if (mode == 1) begin
        exp_perr++;
      end else begin
        exp_ferr++;
      end
      check("rand_data_out", int'(data_out), int'(exp_data));
      check("rand_rx_valid", int'(rx_valid), int'(exp_valid));
    end
    check("rand_irq_rx", n_irq_rx - r0, exp_irq);
    check("rand_err_parity", n_perr - p0, exp_perr);
    check("rand_err_frame", n_ferr - f0, exp_ferr);
    check("rand_overrun", n_ovr - o0, exp_ovr);

    // Reset in the middle of a data bit with a second word queued
    ext_loop = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_in = FS'($urandom); tx_valid = 1'b1;
      step(1);
    end
    tx_valid = 1'b0;
    step(3 * BC + 5);
    reset = 1'b0;
    step(1);
    check("midrst_led", int'(led), 0);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_tx_ready", int'(tx_ready), 1);
    check("midrst_pulses", int'(pulses), 0);
    reset = 1'b1;
    t0 = n_irq_tx; r0 = n_irq_rx; p0 = n_perr; f0 = n_ferr; o0 = n_ovr; l0 = n_led_hi;
    step(3 * FRAME_CYC);
    check("midrst_no_irq_tx", n_irq_tx - t0, 0);
    check("midrst_led_quiet", n_led_hi - l0, 0);

    // One-cycle glitch on signal must be rejected
    ext_loop = 1'b0;
    sig_drv = 1'b1;
    step(1);
    sig_drv = 1'b0;
    step(4 * BC);
    check("glitch_no_irq_rx", n_irq_rx - r0, 0);
    check("glitch_no_errs", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);
    check("glitch_rx_valid", int'(rx_valid), 0);
    check("pulse_width", n_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
